// File: rtl/hazard_controller_if.sv
// hazard_controller_if: decoder/pipeline-side signal bundle for the hazard controller
interface hazard_controller_if #(parameter int CNT_W = 16);
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_Rt;
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic             ID_Jump;
    logic             ID_Branch;
    logic             BranchTaken;
    logic             EXMEM_LB4;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             PipeHold;
    logic             IDEX_Bubble;
    logic             RedirectEn;
    logic             IFID_JFlush;
    logic [1:0]       LB4ByteIdx;
    logic [CNT_W-1:0] StallCycles;

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, ID_Jump, ID_Branch, BranchTaken, EXMEM_LB4,
        output PCWrite, IFIDWrite, PipeHold, IDEX_Bubble, RedirectEn, IFID_JFlush, LB4ByteIdx, StallCycles
    );

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, ID_Jump, ID_Branch, BranchTaken, EXMEM_LB4,
        input  PCWrite, IFIDWrite, PipeHold, IDEX_Bubble, RedirectEn, IFID_JFlush, LB4ByteIdx, StallCycles
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stalls, branch/jump squash and LB4 four-byte pipeline freeze
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input logic                Clock,
    input logic                Reset_n,
    hazard_controller_if.slave bus
);
    typedef enum logic {RUN, HOLD} state_t;

    state_t           state;
    logic [1:0]       idx;
    logic             flush_pend;
    logic [CNT_W-1:0] stall_cnt;
    logic             lu;
    logic             run;

    // A squash in flight masks the hazard: the squashed instruction's operands don't matter.
    assign lu = bus.IDEX_MemRead & (bus.IDEX_Rt != 5'd0) &
                (bus.IDEX_Rt == bus.IFID_Rs | bus.IDEX_Rt == bus.IFID_Rt) & ~flush_pend;
    assign run = (state == RUN) & ~bus.EXMEM_LB4;

    // Outputs decode from registered state plus current inputs; LB4 entry outranks everything.
    always_comb begin
        bus.PCWrite     = run & ~lu;
        bus.IFIDWrite   = run & ~lu;
        bus.IDEX_Bubble = run & (lu | flush_pend);
        bus.RedirectEn  = run & (bus.ID_Jump | (bus.ID_Branch & bus.BranchTaken)) & ~lu & ~flush_pend;
        bus.PipeHold    = (state == RUN) ? bus.EXMEM_LB4 : (idx != 2'd3);
        bus.LB4ByteIdx  = (state == HOLD) ? idx : 2'd0;
        bus.IFID_JFlush = flush_pend;
        bus.StallCycles = stall_cnt;
    end

    // State, byte index, pending squash and saturating stall counter.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= RUN;
            idx        <= 2'd0;
            flush_pend <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (state == RUN) begin
                if (bus.EXMEM_LB4) begin
                    state <= HOLD;
                    idx   <= 2'd1;
                end
            end else begin
                state <= (idx == 2'd3) ? RUN : HOLD;
                idx   <= idx + 2'd1;
            end
            if (bus.RedirectEn)
                flush_pend <= 1'b1;
            else if (flush_pend && !bus.PipeHold)
                flush_pend <= 1'b0;
            if (!bus.PCWrite && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors with hand-computed expectations for hazard_controller
module tb_hazard_controller;
    logic Clock = 1'b0;
    logic Reset_n;
    int   n_checks = 0;
    int   n_pass = 0;

    hazard_controller_if #(.CNT_W(16)) bus ();

    hazard_controller #(.CNT_W(16)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    always #5 Clock = ~Clock;

    // {PCWrite, IFIDWrite, PipeHold, IDEX_Bubble, RedirectEn, IFID_JFlush, LB4ByteIdx}
    function automatic logic [7:0] outs();
        return {bus.PCWrite, bus.IFIDWrite, bus.PipeHold, bus.IDEX_Bubble,
                bus.RedirectEn, bus.IFID_JFlush, bus.LB4ByteIdx};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.IDEX_MemRead = 0; bus.IDEX_Rt = 0; bus.IFID_Rs = 0; bus.IFID_Rt = 0;
        bus.ID_Jump = 0; bus.ID_Branch = 0; bus.BranchTaken = 0; bus.EXMEM_LB4 = 0;
    endtask

    initial begin
        idle();
        Reset_n = 0;
        #3;
        check("reset_outs", 32'(outs()), 32'h0000_00c0);
        check("reset_stall", 32'(bus.StallCycles), 0);
        tick(); tick();
        Reset_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outs", 32'(outs()), 32'h0000_00c0);
        end
        check("idle_stall", 32'(bus.StallCycles), 0);

        bus.IDEX_MemRead = 1; bus.IDEX_Rt = 8; bus.IFID_Rs = 8;
        #1 check("lu_stall", 32'(outs()), 32'h0000_0010);
        tick(); bus.IDEX_MemRead = 0;
        #1 check("lu_resume", 32'(outs()), 32'h0000_00c0);
        check("lu_stall_cnt", 32'(bus.StallCycles), 1);
        bus.IDEX_MemRead = 1; bus.IDEX_Rt = 0; bus.IFID_Rs = 0;
        #1 check("lu_r0", 32'(outs()), 32'h0000_00c0);
        tick(); idle();
        #1 check("lu_r0_cnt", 32'(bus.StallCycles), 1);

        bus.ID_Branch = 1; bus.BranchTaken = 1;
        #1 check("beq_redirect", 32'(outs()), 32'h0000_00c8);
        tick(); idle();
        #1 check("beq_flush", 32'(outs()), 32'h0000_00d4);
        tick();
        check("beq_after", 32'(outs()), 32'h0000_00c0);
        bus.ID_Branch = 1; bus.BranchTaken = 0;
        #1 check("bne_nt", 32'(outs()), 32'h0000_00c0);
        tick(); idle();
        #1 check("bne_noflush", 32'(outs()), 32'h0000_00c0);

        bus.IDEX_MemRead = 1; bus.IDEX_Rt = 31; bus.IFID_Rs = 31; bus.ID_Jump = 1;
        #1 check("jr_stall", 32'(outs()), 32'h0000_0010);
        tick(); bus.IDEX_MemRead = 0;
        #1 check("jr_redirect", 32'(outs()), 32'h0000_00c8);
        check("jr_stall_cnt", 32'(bus.StallCycles), 2);
        tick(); idle();
        #1 check("jr_flush", 32'(outs()), 32'h0000_00d4);
        tick();
        check("jr_after", 32'(outs()), 32'h0000_00c0);

        bus.EXMEM_LB4 = 1;
        #1 check("lb4_b0", 32'(outs()), 32'h0000_0020);
        tick(); check("lb4_b1", 32'(outs()), 32'h0000_0021);
        tick(); check("lb4_b2", 32'(outs()), 32'h0000_0022);
        tick(); check("lb4_b3", 32'(outs()), 32'h0000_0003);
        bus.EXMEM_LB4 = 0;
        tick(); check("lb4_done", 32'(outs()), 32'h0000_00c0);
        check("lb4_stall_cnt", 32'(bus.StallCycles), 6);

        bus.EXMEM_LB4 = 1;
        tick(); tick();
        check("rst_pre_b2", 32'(outs()), 32'h0000_0022);
        Reset_n = 0; bus.EXMEM_LB4 = 0;
        #1 check("rst_hold_outs", 32'(outs()), 32'h0000_00c0);
        check("rst_hold_stall", 32'(bus.StallCycles), 0);
        tick(); Reset_n = 1;
        tick(); check("rst_run", 32'(outs()), 32'h0000_00c0);

        bus.ID_Jump = 1;
        #1 check("fh_redirect", 32'(outs()), 32'h0000_00c8);
        tick(); bus.ID_Jump = 0; bus.EXMEM_LB4 = 1;
        #1 check("fh_b0", 32'(outs()), 32'h0000_0024);
        tick(); check("fh_b1", 32'(outs()), 32'h0000_0025);
        tick(); check("fh_b2", 32'(outs()), 32'h0000_0026);
        tick(); bus.EXMEM_LB4 = 0;
        #1 check("fh_b3", 32'(outs()), 32'h0000_0007);
        tick(); check("fh_release", 32'(outs()), 32'h0000_00c0);
        check("fh_stall_cnt", 32'(bus.StallCycles), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
